// File: rtl/cam_pkg.sv
// Shared constants and FSM encoding for the camera capture writer.
package cam_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int PIX_W    = 12;

    typedef enum logic [1:0] {
        WAIT_VS_HIGH = 2'd0,
        WAIT_VS_LOW  = 2'd1,
        CAPTURE      = 2'd2
    } cap_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Registers one camera control line and reports its level plus one-cycle
// rise/fall pulses derived from the registered value.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic lvl_q, lvl_d;
    logic prev_q, prev_d;

    // Next values: sample the raw input, keep one cycle of history.
    always_comb begin
        lvl_d  = d;
        prev_d = lvl_q;
    end

    // Input register plus history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            lvl_q  <= lvl_d;
            prev_q <= prev_d;
        end
    end

    assign level = lvl_q;
    assign rise  = lvl_q & ~prev_q;
    assign fall  = ~lvl_q & prev_q;

endmodule

// File: rtl/cam_capture_writer.sv
// Captures an RGB444 byte stream from a camera and writes 12-bit pixels to
// an external FIFO, checking frame geometry on the way.
//
// state        | meaning
// WAIT_VS_HIGH | after reset: wait for vsync high so we never join mid-frame
// WAIT_VS_LOW  | between frames: vsync low marks frame start
// CAPTURE      | assembling pixels; vsync rising edge marks frame end
module cam_capture_writer #(
    parameter int H_ACTIVE = cam_pkg::H_ACTIVE,
    parameter int V_ACTIVE = cam_pkg::V_ACTIVE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cam_vsync,
    input  logic                      cam_href,
    input  logic [7:0]                cam_data,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [cam_pkg::PIX_W-1:0] fifo_din,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic                      overflow,
    output logic [9:0]                o_x_count,
    output logic [8:0]                o_y_count
);

    import cam_pkg::*;

    localparam logic [9:0] X_MAX = 10'(H_ACTIVE);
    localparam logic [8:0] Y_MAX = 9'(V_ACTIVE);

    logic vs_lvl, vs_rise, vs_fall;
    logic href_lvl, href_rise, href_fall;

    cap_state_e        state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic [3:0]        r_q, r_d;
    logic              phase_q, phase_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic              wr_q, wr_d;
    logic [PIX_W-1:0]  din_q, din_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;

    sync_edge_det u_vsync (
        .clk   (clk),
        .rst   (rst),
        .d     (cam_vsync),
        .level (vs_lvl),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    sync_edge_det u_href (
        .clk   (clk),
        .rst   (rst),
        .d     (cam_href),
        .level (href_lvl),
        .rise  (href_rise),
        .fall  (href_fall)
    );

    // Next-state, pixel assembly, counters and status flags.
    always_comb begin
        state_d = state_q;
        data_d  = cam_data;
        r_d     = r_q;
        phase_d = phase_q;
        x_d     = x_q;
        y_d     = y_q;
        wr_d    = 1'b0;
        din_d   = din_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ovf_d   = ovf_q;

        case (state_q)
            WAIT_VS_HIGH: begin
                if (vs_lvl) state_d = WAIT_VS_LOW;
            end

            WAIT_VS_LOW: begin
                // Only ever entered with vsync high, so a fall is the first low.
                if (vs_fall) begin
                    state_d = CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end

            CAPTURE: begin
                if (href_rise && (y_q == Y_MAX)) err_d = 1'b1;

                // A vsync rise takes precedence: the byte arriving with it is dropped.
                if (href_lvl && !vs_rise) begin
                    if (y_q == Y_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        phase_d = ~phase_q;
                        if (!phase_q) begin
                            r_d = data_q[3:0];
                        end else if (x_q == X_MAX) begin
                            err_d = 1'b1;
                        end else begin
                            x_d = x_q + 10'd1;
                            if (fifo_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                wr_d  = 1'b1;
                                din_d = {r_q, data_q};
                            end
                        end
                    end
                end

                if (href_fall) begin
                    if (phase_q) err_d = 1'b1;
                    if (x_q != X_MAX) err_d = 1'b1;
                    if (x_q != '0) y_d = y_q + 9'd1;
                    x_d     = '0;
                    phase_d = 1'b0;
                end

                if (vs_rise) begin
                    if (href_lvl) err_d = 1'b1;
                    phase_d = 1'b0;
                    state_d = WAIT_VS_LOW;
                    done_d  = (y_d == Y_MAX) && !err_d;
                end
            end

            default: state_d = WAIT_VS_HIGH;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_VS_HIGH;
            data_q  <= '0;
            r_q     <= '0;
            phase_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            wr_q    <= 1'b0;
            din_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            r_q     <= r_d;
            phase_q <= phase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wr_q    <= wr_d;
            din_q   <= din_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign fifo_wr_en = wr_q;
    assign fifo_din   = din_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign overflow   = ovf_q;
    assign o_x_count  = x_q;
    assign o_y_count  = y_q;

endmodule

// File: doc/cam_capture_writer.md
CAM_CAPTURE_WRITER -- requirements
Module: cam_capture_writer

Interface
REQ-001 Parameter H_ACTIVE, default 640, meaning the number of pixels per active line.
REQ-002 Parameter V_ACTIVE, default 480, meaning the number of active lines per frame.
REQ-003 Port clk, input, 1 bit; the single clock (camera pixel clock domain), and all logic SHALL use its rising edge.
REQ-004 Port rst, input, 1 bit; synchronous, active-high reset.
REQ-005 Port cam_vsync, input, 1 bit; frame sync, high between frames.
REQ-006 Port cam_href, input, 1 bit; line valid, high during active bytes.
REQ-007 Port cam_data, input, 8 bits; RGB444 byte stream.
REQ-008 Port fifo_full, input, 1 bit; FIFO cannot accept a write this cycle.
REQ-009 Port fifo_wr_en, output reg, 1 bit; one-cycle write strobe.
REQ-010 Port fifo_din, output reg, 12 bits; pixel {R[3:0],G[3:0],B[3:0]}.
REQ-011 Port frame_done, output reg, 1 bit; one-cycle pulse when a frame completes at full size.
REQ-012 Port frame_err, output reg, 1 bit; sticky flag for a frame-size mismatch, cleared at the next frame start.
REQ-013 Port overflow, output reg, 1 bit; sticky flag for a pixel dropped on fifo_full, cleared at the next frame start.
REQ-014 Port o_x_count, output, 10 bits, and port o_y_count, output, 9 bits; current pixel and line counters.

Function
REQ-015 All camera inputs SHALL be registered once before use; every timing below refers to these registered values.
REQ-016 FSM states: WAIT_VS_HIGH, WAIT_VS_LOW, CAPTURE.
- WAIT_VS_HIGH -> WAIT_VS_LOW when vsync=1.
- WAIT_VS_LOW -> CAPTURE when vsync=0 (frame start).
- CAPTURE -> WAIT_VS_LOW on the vsync rising edge (frame end).
REQ-017 Frame start SHALL clear x_count, y_count, byte_phase, overflow and frame_err.
REQ-018 In CAPTURE, on each edge with href=1, byte_phase SHALL toggle.
- Phase 0: latch R = data[3:0].
- Phase 1: form the pixel {R, data[7:4], data[3:0]}.
REQ-019 On a phase-1 edge with fifo_full=0, fifo_din SHALL take the pixel and fifo_wr_en SHALL be 1 for exactly the next cycle.
- This gives a latency of one cycle from the registered second byte to the write strobe.
REQ-020 On a phase-1 edge with fifo_full=1, no write SHALL occur, overflow SHALL set, and x_count SHALL still increment.
REQ-021 x_count SHALL increment per formed pixel and saturate at H_ACTIVE; pixels beyond H_ACTIVE SHALL be dropped without a write and SHALL set frame_err.
REQ-022 On the href falling edge:
- if byte_phase=1, the half pixel is discarded and frame_err sets;
- if x_count≠H_ACTIVE, frame_err sets;
- y_count increments if x_count>0;
- x_count and byte_phase clear.
REQ-023 Lines arriving after y_count=V_ACTIVE SHALL write nothing and SHALL set frame_err.
REQ-024 On frame end, frame_done SHALL pulse for one cycle only if y_count=V_ACTIVE and frame_err=0 (including errors set in the same cycle).
REQ-025 A vsync rising edge while href=1 SHALL end the frame, discard any partial pixel, and set frame_err.
REQ-026 fifo_wr_en SHALL never be asserted outside CAPTURE, nor on a cycle following an edge where fifo_full=1.

Reset
REQ-027 On rst=1 at a clock edge, the following SHALL take the values shown, and the input register stage SHALL clear:
- state = WAIT_VS_HIGH;
- fifo_wr_en, fifo_din, frame_done, frame_err, overflow, x_count, y_count, byte_phase = 0.
REQ-028 A reset asserted mid-frame SHALL discard the remainder of that frame; capture SHALL resume only after a full vsync high-then-low sequence.

Structure
REQ-029 A shared package cam_pkg SHALL hold H_ACTIVE, V_ACTIVE, PIX_W=12, and the FSM state encodings.
REQ-030 The edge detection for vsync and href SHALL be one sub-module, sync_edge_det: it registers the input and outputs the level plus rise and fall pulses.
REQ-031 The block SHALL be RTL-only with no vendor primitives; the FIFO is external.

Verification
REQ-032 Nominal frame: 480 lines of 1280 bytes each, byte pairs 0x0A/0xBC -> 307200 writes of 0xABC, then frame_done=1 for one cycle with frame_err=0 and overflow=0.
REQ-033 Backpressure: fifo_full=1 on pixel 5 of line 0 -> that pixel is not written, overflow=1 until the next frame start, and the frame still totals 307199 writes.
REQ-034 Odd-length line: line 3 carries 1279 bytes -> 639 writes on that line, frame_err=1, and no frame_done at frame end.
REQ-035 Reset mid-frame: rst asserted at line 100 -> all outputs are 0 the next cycle; the rest of the frame produces no writes; the next full frame produces 307200 writes.
REQ-036 Startup: capture starts with vsync already low -> no writes until a vsync high-then-low sequence occurs.
REQ-037 Oversized frame: 482 lines and 642-pixel lines -> exactly 640 writes per line and 480 lines written, with frame_err=1.
